// File: rtl/dram_arb_pkg.sv
// Shared constants for the DDR2 application-interface arbiter.
package dram_arb_pkg;
  localparam int APP_DATA_W = 144;
  localparam int APP_BE_W   = 18;
  localparam int APP_ADDR_W = 32;
  localparam int READ_BEATS = 2;
endpackage

// File: rtl/dram_arb_tag_fifo.sv
// Synchronous tag FIFO: remembers which port issued each outstanding read,
// so that returning read beats can be routed back in issue order.
module dram_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic                     clk0,
  input  logic                     rst0,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk0) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin sharer of one DDR2 application interface among NUM_PORTS
// requesters: command grant, two-beat write sequencing, and in-order
// routing of two-beat read returns via a tag FIFO.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int PORT_BITS      = 1,
  parameter int RD_OUTSTANDING = 16
) (
  input  logic                             clk0,
  input  logic                             rst0,
  input  logic                             phy_rdy,
  input  logic [APP_ADDR_W*NUM_PORTS-1:0]  req_cmd_addr,
  input  logic [NUM_PORTS-1:0]             req_cmd_rnw,
  input  logic [NUM_PORTS-1:0]             req_cmd_valid,
  output logic [NUM_PORTS-1:0]             req_cmd_ack,
  input  logic [APP_DATA_W*NUM_PORTS-1:0]  req_wr_data,
  input  logic [APP_BE_W*NUM_PORTS-1:0]    req_wr_be,
  output logic [APP_DATA_W-1:0]            req_rd_data,
  output logic [NUM_PORTS-1:0]             req_rd_valid,
  output logic                             arb_rd_err,
  output logic [APP_ADDR_W-1:0]            app_cmd_addr,
  output logic                             app_cmd_rnw,
  output logic                             app_cmd_valid,
  output logic [APP_DATA_W-1:0]            app_wr_data,
  output logic [APP_BE_W-1:0]              app_wr_be,
  input  logic [APP_DATA_W-1:0]            app_rd_data,
  input  logic                             app_rd_valid
);
  localparam int CNT_W  = $clog2(RD_OUTSTANDING) + 1;
  localparam int BEAT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;

  logic [PORT_BITS-1:0] rr_ptr;
  logic                 wr_beat1_p1;
  logic [PORT_BITS-1:0] wr_port_p1;

  logic                 issue_ok;
  logic                 rd_room;
  logic [NUM_PORTS-1:0] eligible;
  logic [PORT_BITS:0]   pick;
  logic                 gnt_vld;
  logic [PORT_BITS-1:0] gnt_port;
  logic                 gnt_rnw;
  logic [PORT_BITS-1:0] rr_next;
  logic [PORT_BITS-1:0] data_port;
  logic                 load_data;

  logic                 tag_push;
  logic                 tag_pop;
  logic [PORT_BITS-1:0] tag_head;
  logic                 tag_full;
  logic                 tag_empty;
  logic [CNT_W-1:0]     tag_count;
  logic [BEAT_W-1:0]    rd_beat;
  logic                 rd_accept;
  logic                 rd_last;
  logic [NUM_PORTS-1:0] rd_sel;

  // First eligible port at or after start, as {found, port}.
  function automatic logic [PORT_BITS:0] rr_pick(input logic [NUM_PORTS-1:0] elig,
                                                 input logic [PORT_BITS-1:0] start);
    logic                 found;
    logic [PORT_BITS-1:0] port;
    int                   idx;
    found = 1'b0;
    port  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(start) + k) % NUM_PORTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        port  = PORT_BITS'(idx);
      end
    end
    return {found, port};
  endfunction

  // Issue gate and round-robin grant; a read blocked by a full tag FIFO is skipped.
  always_comb begin
    issue_ok = phy_rdy && !wr_beat1_p1 && !rst0;
    rd_room  = (tag_count < CNT_W'(RD_OUTSTANDING));
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_cmd_valid[i] && (!req_cmd_rnw[i] || rd_room);
    end
    pick        = rr_pick(eligible, rr_ptr);
    gnt_vld     = issue_ok && pick[PORT_BITS];
    gnt_port    = pick[PORT_BITS-1:0];
    gnt_rnw     = req_cmd_rnw[gnt_port];
    rr_next     = (gnt_port == PORT_BITS'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
    req_cmd_ack = '0;
    if (gnt_vld) req_cmd_ack[gnt_port] = 1'b1;
    data_port   = wr_beat1_p1 ? wr_port_p1 : gnt_port;
    load_data   = (gnt_vld && !gnt_rnw) || wr_beat1_p1;
  end

  // Stage p1: registered command, beat0 on grant, beat1 from the remembered port the cycle after.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      app_cmd_valid <= 1'b0;
      app_cmd_rnw   <= 1'b0;
      app_cmd_addr  <= '0;
      app_wr_data   <= '0;
      app_wr_be     <= '0;
      wr_beat1_p1   <= 1'b0;
      wr_port_p1    <= '0;
      rr_ptr        <= '0;
    end else begin
      app_cmd_valid <= gnt_vld;
      app_cmd_rnw   <= gnt_vld && gnt_rnw;
      app_cmd_addr  <= gnt_vld ? req_cmd_addr[gnt_port*APP_ADDR_W +: APP_ADDR_W] : '0;
      app_wr_data   <= load_data ? req_wr_data[data_port*APP_DATA_W +: APP_DATA_W] : '0;
      app_wr_be     <= load_data ? req_wr_be[data_port*APP_BE_W +: APP_BE_W] : '0;
      wr_beat1_p1   <= gnt_vld && !gnt_rnw;
      if (gnt_vld) begin
        wr_port_p1 <= gnt_port;
        rr_ptr     <= rr_next;
      end
    end
  end

  // Read-return routing: head tag selects the port; last beat of a burst retires the tag.
  always_comb begin
    rd_accept = app_rd_valid && !tag_empty;
    rd_last   = (rd_beat == BEAT_W'(READ_BEATS - 1));
    tag_pop   = rd_accept && rd_last;
    tag_push  = gnt_vld && gnt_rnw && !tag_full;
    rd_sel    = '0;
    rd_sel[tag_head] = 1'b1;
  end

  // Stage p1 of the return path: registered data/qualifier, beat counter, sticky orphan-return flag.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_beat      <= '0;
      req_rd_valid <= '0;
      req_rd_data  <= '0;
      arb_rd_err   <= 1'b0;
    end else begin
      if (rd_accept) rd_beat <= rd_last ? '0 : rd_beat + 1'b1;
      req_rd_valid <= rd_accept ? rd_sel : '0;
      req_rd_data  <= rd_accept ? app_rd_data : '0;
      if (app_rd_valid && tag_empty) arb_rd_err <= 1'b1;
    end
  end

  dram_arb_tag_fifo #(
    .WIDTH (PORT_BITS),
    .DEPTH (RD_OUTSTANDING)
  ) u_tag_fifo (
    .clk0      (clk0),
    .rst0      (rst0),
    .push      (tag_push),
    .push_data (gnt_port),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );
endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter (2 ports, 16 outstanding reads).
module tb_dram_arbiter;
  logic         clk0 = 1'b0;
  logic         rst0;
  logic         phy_rdy;
  logic [63:0]  req_cmd_addr;
  logic [1:0]   req_cmd_rnw;
  logic [1:0]   req_cmd_valid;
  logic [1:0]   req_cmd_ack;
  logic [287:0] req_wr_data;
  logic [35:0]  req_wr_be;
  logic [143:0] req_rd_data;
  logic [1:0]   req_rd_valid;
  logic         arb_rd_err;
  logic [31:0]  app_cmd_addr;
  logic         app_cmd_rnw;
  logic         app_cmd_valid;
  logic [143:0] app_wr_data;
  logic [17:0]  app_wr_be;
  logic [143:0] app_rd_data;
  logic         app_rd_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  dram_arbiter #(.NUM_PORTS(2), .PORT_BITS(1), .RD_OUTSTANDING(16)) dut (
    .clk0          (clk0),
    .rst0          (rst0),
    .phy_rdy       (phy_rdy),
    .req_cmd_addr  (req_cmd_addr),
    .req_cmd_rnw   (req_cmd_rnw),
    .req_cmd_valid (req_cmd_valid),
    .req_cmd_ack   (req_cmd_ack),
    .req_wr_data   (req_wr_data),
    .req_wr_be     (req_wr_be),
    .req_rd_data   (req_rd_data),
    .req_rd_valid  (req_rd_valid),
    .arb_rd_err    (arb_rd_err),
    .app_cmd_addr  (app_cmd_addr),
    .app_cmd_rnw   (app_cmd_rnw),
    .app_cmd_valid (app_cmd_valid),
    .app_wr_data   (app_wr_data),
    .app_wr_be     (app_wr_be),
    .app_rd_data   (app_rd_data),
    .app_rd_valid  (app_rd_valid)
  );

  function automatic logic [143:0] rand144();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[143:0];
  endfunction

  task automatic drive_idle();
    phy_rdy       = 1'b1;
    req_cmd_addr  = '0;
    req_cmd_rnw   = '0;
    req_cmd_valid = '0;
    req_wr_data   = '0;
    req_wr_be     = '0;
    app_rd_data   = '0;
    app_rd_valid  = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge with state reset.
  task automatic apply_reset();
    drive_idle();
    rst0 = 1'b1;
    @(negedge clk0);
    rst0 = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst0          = 1'b1;
    req_cmd_valid = 2'b11;
    req_cmd_rnw   = 2'b11;
    app_rd_valid  = 1'b1;
    app_rd_data   = rand144();
    #2;
    checks++; if (req_cmd_ack !== 2'b00) begin errors++; $display("FAIL rst_ack_comb: got %b want 00", req_cmd_ack); end
    @(negedge clk0); #2;
    checks++; if (app_cmd_valid !== 1'b0 || app_cmd_addr !== 32'h0 || app_cmd_rnw !== 1'b0) begin
      errors++; $display("FAIL rst_cmd: valid=%b addr=%h rnw=%b want 0/0/0", app_cmd_valid, app_cmd_addr, app_cmd_rnw); end
    checks++; if (app_wr_data !== 144'h0 || app_wr_be !== 18'h0) begin
      errors++; $display("FAIL rst_wdata: data=%h be=%h want 0", app_wr_data, app_wr_be); end
    checks++; if (req_rd_valid !== 2'b00 || req_rd_data !== 144'h0 || arb_rd_err !== 1'b0) begin
      errors++; $display("FAIL rst_rd: valid=%b data=%h err=%b want 0", req_rd_valid, req_rd_data, arb_rd_err); end
    drive_idle();
    rst0 = 1'b0;
    @(negedge clk0);
  endtask

  task automatic test_write();
    logic [143:0] a, b, c, d;
    logic [17:0]  be0, be1;
    a = {36{4'hA}}; b = {36{4'hB}}; c = rand144(); d = rand144();
    be0 = 18'($urandom()); be1 = 18'($urandom());
    // cycle N: P0 write request
    req_cmd_valid = 2'b01; req_cmd_rnw = 2'b00;
    req_cmd_addr[31:0] = 32'h100; req_wr_data[143:0] = a; req_wr_be[17:0] = be0;
    #2;
    checks++; if (req_cmd_ack !== 2'b01) begin errors++; $display("FAIL wr_ack_n: got %b want 01", req_cmd_ack); end
    @(negedge clk0);
    // N+1: P0 beat1 on its lines, P1 asks for a write but must wait
    req_cmd_valid = 2'b10; req_wr_data[143:0] = b; req_wr_be[17:0] = be1;
    req_cmd_addr[63:32] = 32'h200; req_wr_data[287:144] = c;
    #2;
    checks++; if (req_cmd_ack !== 2'b00) begin errors++; $display("FAIL wr_no_ack_n1: got %b want 00", req_cmd_ack); end
    checks++; if (app_cmd_valid !== 1'b1 || app_cmd_addr !== 32'h100 || app_cmd_rnw !== 1'b0) begin
      errors++; $display("FAIL wr_cmd_n1: valid=%b addr=%h rnw=%b want 1/100/0", app_cmd_valid, app_cmd_addr, app_cmd_rnw); end
    checks++; if (app_wr_data !== a || app_wr_be !== be0) begin
      errors++; $display("FAIL wr_beat0: data=%h be=%h want %h/%h", app_wr_data, app_wr_be, a, be0); end
    @(negedge clk0);
    // N+2: beat1 visible, P1 now granted
    #2;
    checks++; if (app_wr_data !== b || app_wr_be !== be1 || app_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL wr_beat1: data=%h be=%h cv=%b want %h/%h/0", app_wr_data, app_wr_be, app_cmd_valid, b, be1); end
    checks++; if (req_cmd_ack !== 2'b10) begin errors++; $display("FAIL wr_ack_p1: got %b want 10", req_cmd_ack); end
    @(negedge clk0);
    req_cmd_valid = 2'b00; req_wr_data[287:144] = d;
    #2;
    checks++; if (app_cmd_valid !== 1'b1 || app_cmd_addr !== 32'h200 || app_wr_data !== c) begin
      errors++; $display("FAIL wr_p1_beat0: cv=%b addr=%h data=%h want 1/200/%h", app_cmd_valid, app_cmd_addr, app_wr_data, c); end
    @(negedge clk0);
    drive_idle();
    #2;
    checks++; if (app_wr_data !== d) begin errors++; $display("FAIL wr_p1_beat1: got %h want %h", app_wr_data, d); end
    @(negedge clk0); #2;
    checks++; if (app_wr_data !== 144'h0 || app_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL wr_idle_zero: data=%h cv=%b want 0/0", app_wr_data, app_cmd_valid); end
    @(negedge clk0);
  endtask

  task automatic test_rr_reads();
    logic [31:0]  last_addr;
    logic [143:0] prev_data;
    logic [1:0]   exp;
    last_addr = '0; prev_data = '0;
    req_cmd_rnw = 2'b11;
    req_cmd_addr = {$urandom(), $urandom()};
    for (int g = 0; g < 9; g++) begin
      req_cmd_valid = (g < 8) ? 2'b11 : 2'b00;
      #2;
      exp = (g < 8) ? (2'b01 << (g % 2)) : 2'b00;
      checks++; if (req_cmd_ack !== exp) begin errors++; $display("FAIL rr_ack g=%0d: got %b want %b", g, req_cmd_ack, exp); end
      if (g > 0) begin
        checks++; if (app_cmd_valid !== 1'b1 || app_cmd_rnw !== 1'b1 || app_cmd_addr !== last_addr) begin
          errors++; $display("FAIL rr_cmd g=%0d: cv=%b rnw=%b addr=%h want 1/1/%h", g, app_cmd_valid, app_cmd_rnw, app_cmd_addr, last_addr); end
      end
      if (g < 8) last_addr = req_cmd_addr[(g % 2)*32 +: 32];
      @(negedge clk0);
      if (g < 8) req_cmd_addr[(g % 2)*32 +: 32] = $urandom();
    end
    for (int b = 0; b < 17; b++) begin
      app_rd_valid = (b < 16);
      app_rd_data  = rand144();
      #2;
      if (b > 0) begin
        exp = 2'b01 << (((b - 1) / 2) % 2);
        checks++; if (req_rd_valid !== exp || req_rd_data !== prev_data) begin
          errors++; $display("FAIL rr_ret b=%0d: valid=%b data=%h want %b/%h", b, req_rd_valid, req_rd_data, exp, prev_data); end
      end
      prev_data = app_rd_data;
      @(negedge clk0);
    end
    drive_idle();
    #2;
    checks++; if (req_rd_valid !== 2'b00 || arb_rd_err !== 1'b0) begin
      errors++; $display("FAIL rr_ret_end: valid=%b err=%b want 00/0", req_rd_valid, arb_rd_err); end
    @(negedge clk0);
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_ack [9];
    logic [1:0] exp_rv  [9];
    exp_ack = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    exp_rv  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
    apply_reset();
    req_cmd_rnw = 2'b10;
    for (int i = 0; i < 16; i++) begin
      req_cmd_valid = 2'b10;
      req_cmd_addr[63:32] = $urandom();
      #2;
      checks++; if (req_cmd_ack !== 2'b10) begin errors++; $display("FAIL bp_fill i=%0d: got %b want 10", i, req_cmd_ack); end
      @(negedge clk0);
    end
    // steps: held, held, P0 write wins, beat1, held, ret beat0, ret beat1, slot freed, full again
    for (int s = 0; s < 9; s++) begin
      req_cmd_valid = (s == 2) ? 2'b11 : 2'b10;
      app_rd_valid  = (s == 5 || s == 6);
      app_rd_data   = rand144();
      #2;
      checks++; if (req_cmd_ack !== exp_ack[s]) begin errors++; $display("FAIL bp_ack s=%0d: got %b want %b", s, req_cmd_ack, exp_ack[s]); end
      checks++; if (req_rd_valid !== exp_rv[s]) begin errors++; $display("FAIL bp_ret s=%0d: got %b want %b", s, req_rd_valid, exp_rv[s]); end
      @(negedge clk0);
    end
    apply_reset();
  endtask

  task automatic test_phy_rdy();
    logic [143:0] x;
    x = rand144();
    phy_rdy = 1'b0; req_cmd_valid = 2'b11; req_cmd_rnw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (req_cmd_ack !== 2'b00 || (i > 0 && app_cmd_valid !== 1'b0)) begin
        errors++; $display("FAIL phy_low i=%0d: ack=%b cv=%b want 00/0", i, req_cmd_ack, app_cmd_valid); end
      @(negedge clk0);
    end
    phy_rdy = 1'b1;
    #2;
    checks++; if (req_cmd_ack !== 2'b01) begin errors++; $display("FAIL phy_rise_ack: got %b want 01", req_cmd_ack); end
    @(negedge clk0);
    req_cmd_valid = 2'b10; req_cmd_rnw = 2'b00;
    #2;
    checks++; if (req_cmd_ack !== 2'b10 || app_cmd_valid !== 1'b1 || app_cmd_rnw !== 1'b1) begin
      errors++; $display("FAIL phy_wr_ack: ack=%b cv=%b rnw=%b want 10/1/1", req_cmd_ack, app_cmd_valid, app_cmd_rnw); end
    @(negedge clk0);
    phy_rdy = 1'b0; req_cmd_valid = 2'b01; req_cmd_rnw = 2'b01; req_wr_data[287:144] = x;
    #2;
    checks++; if (req_cmd_ack !== 2'b00 || app_cmd_valid !== 1'b1 || app_cmd_rnw !== 1'b0) begin
      errors++; $display("FAIL phy_fall: ack=%b cv=%b rnw=%b want 00/1/0", req_cmd_ack, app_cmd_valid, app_cmd_rnw); end
    @(negedge clk0);
    #2;
    checks++; if (app_wr_data !== x || req_cmd_ack !== 2'b00) begin
      errors++; $display("FAIL phy_fall_beat1: data=%h ack=%b want %h/00", app_wr_data, req_cmd_ack, x); end
    @(negedge clk0);
    phy_rdy = 1'b1;
    #2;
    checks++; if (req_cmd_ack !== 2'b01) begin errors++; $display("FAIL phy_resume: got %b want 01", req_cmd_ack); end
    @(negedge clk0);
    apply_reset();
  endtask

  task automatic test_rd_err();
    app_rd_valid = 1'b1; app_rd_data = rand144();
    #2;
    checks++; if (arb_rd_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", arb_rd_err); end
    @(negedge clk0);
    app_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (arb_rd_err !== 1'b1 || req_rd_valid !== 2'b00) begin
        errors++; $display("FAIL err_sticky i=%0d: err=%b rv=%b want 1/00", i, arb_rd_err, req_rd_valid); end
      @(negedge clk0);
    end
    apply_reset();
    #2;
    checks++; if (arb_rd_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", arb_rd_err); end
    @(negedge clk0);
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    req_cmd_valid = 2'b11; req_cmd_rnw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #2;
      exp = 2'b01 << (i % 2);
      checks++; if (req_cmd_ack !== exp) begin errors++; $display("FAIL rm_ack i=%0d: got %b want %b", i, req_cmd_ack, exp); end
      @(negedge clk0);
    end
    rst0 = 1'b1;
    #2;
    checks++; if (req_cmd_ack !== 2'b00) begin errors++; $display("FAIL rm_ack_in_rst: got %b want 00", req_cmd_ack); end
    @(negedge clk0);
    rst0 = 1'b0; req_cmd_valid = 2'b00; app_rd_valid = 1'b1; app_rd_data = rand144();
    #2;
    checks++; if (app_cmd_valid !== 1'b0 || app_cmd_addr !== 32'h0 || app_cmd_rnw !== 1'b0 ||
                  req_rd_valid !== 2'b00 || arb_rd_err !== 1'b0 || app_wr_data !== 144'h0) begin
      errors++; $display("FAIL rm_outputs: cv=%b addr=%h rnw=%b rv=%b err=%b want all 0",
                         app_cmd_valid, app_cmd_addr, app_cmd_rnw, req_rd_valid, arb_rd_err); end
    @(negedge clk0);
    app_rd_valid = 1'b0; req_cmd_valid = 2'b11;
    #2;
    checks++; if (arb_rd_err !== 1'b1 || req_rd_valid !== 2'b00) begin
      errors++; $display("FAIL rm_fifo_empty: err=%b rv=%b want 1/00", arb_rd_err, req_rd_valid); end
    checks++; if (req_cmd_ack !== 2'b01) begin errors++; $display("FAIL rm_ptr: got %b want 01", req_cmd_ack); end
    @(negedge clk0);
    apply_reset();
  endtask

  task automatic test_random();
    logic [1:0]   pend, rnw_r, exp_ack;
    int           m_ptr, m_wport, m_beat, eg;
    bit           m_beat1, e_cmd_valid, e_rnw, e_chk, e_err;
    logic [31:0]  e_addr;
    logic [143:0] e_data, e_rd_data;
    logic [17:0]  e_be;
    logic [1:0]   e_rd_valid;
    int           m_tags[$];
    pend = '0; rnw_r = '0; m_ptr = 0; m_wport = 0; m_beat = 0; m_beat1 = 0;
    e_cmd_valid = 0; e_rnw = 0; e_chk = 1; e_err = 0; e_addr = '0; e_data = '0; e_be = '0;
    e_rd_valid = '0; e_rd_data = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom() % 3 == 0)) begin
          pend[p]  = 1'b1;
          rnw_r[p] = ($urandom() % 5) < 3;
          req_cmd_addr[p*32 +: 32] = $urandom();
        end
        req_wr_data[p*144 +: 144] = rand144();
        req_wr_be[p*18 +: 18]     = 18'($urandom());
      end
      req_cmd_valid = pend;
      req_cmd_rnw   = rnw_r;
      phy_rdy       = ($urandom() % 8) != 0;
      app_rd_valid  = (m_tags.size() > 0) ? ($urandom() % 2 == 0) : ($urandom() % 20 == 0);
      app_rd_data   = rand144();
      #2;
      eg = -1;
      if (phy_rdy && !m_beat1) begin
        for (int k = 0; k < 2; k++) begin
          int p;
          p = (m_ptr + k) % 2;
          if (eg < 0 && pend[p] && (!rnw_r[p] || m_tags.size() < 16)) eg = p;
        end
      end
      exp_ack = (eg >= 0) ? (2'b01 << eg) : 2'b00;
      checks++; if (req_cmd_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack c=%0d: got %b want %b", cyc, req_cmd_ack, exp_ack); end
      checks++; if (app_cmd_valid !== e_cmd_valid || (e_cmd_valid && (app_cmd_addr !== e_addr || app_cmd_rnw !== e_rnw))) begin
        errors++; $display("FAIL rnd_cmd c=%0d: cv=%b addr=%h rnw=%b want %b/%h/%b", cyc, app_cmd_valid, app_cmd_addr, app_cmd_rnw, e_cmd_valid, e_addr, e_rnw); end
      if (e_chk) begin
        checks++; if (app_wr_data !== e_data || app_wr_be !== e_be) begin
          errors++; $display("FAIL rnd_wdata c=%0d: data=%h be=%h want %h/%h", cyc, app_wr_data, app_wr_be, e_data, e_be); end
      end
      checks++; if (req_rd_valid !== e_rd_valid || (e_rd_valid != 0 && req_rd_data !== e_rd_data) || arb_rd_err !== e_err) begin
        errors++; $display("FAIL rnd_ret c=%0d: rv=%b data=%h err=%b want %b/%h/%b", cyc, req_rd_valid, req_rd_data, arb_rd_err, e_rd_valid, e_rd_data, e_err); end
      // expectations for the next cycle
      e_cmd_valid = (eg >= 0);
      if (eg >= 0) begin
        e_addr = req_cmd_addr[eg*32 +: 32];
        e_rnw  = rnw_r[eg];
      end
      if (eg >= 0 && !rnw_r[eg]) begin
        e_data = req_wr_data[eg*144 +: 144]; e_be = req_wr_be[eg*18 +: 18]; e_chk = 1;
      end else if (m_beat1) begin
        e_data = req_wr_data[m_wport*144 +: 144]; e_be = req_wr_be[m_wport*18 +: 18]; e_chk = 1;
      end else if (eg < 0) begin
        e_data = '0; e_be = '0; e_chk = 1;
      end else begin
        e_chk = 0;
      end
      e_rd_valid = 2'b00;
      if (app_rd_valid) begin
        if (m_tags.size() == 0) begin
          e_err = 1;
        end else begin
          e_rd_valid = 2'b01 << m_tags[0];
          e_rd_data  = app_rd_data;
          m_beat++;
          if (m_beat == 2) begin
            m_beat = 0;
            void'(m_tags.pop_front());
          end
        end
      end
      if (eg >= 0 && rnw_r[eg]) m_tags.push_back(eg);
      m_beat1 = (eg >= 0) && !rnw_r[eg];
      if (eg >= 0) begin
        m_wport  = eg;
        m_ptr    = (eg + 1) % 2;
        pend[eg] = 1'b0;
      end
      @(negedge clk0);
    end
    drive_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_rr_reads();
    test_backpressure();
    test_phy_rdy();
    test_rd_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
